// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer_pkg
// Purpose  : Shared FSM encodings, default geometry and a counter-width
//            helper for the mux scan sequencer and its dwell timer.
// Revision : 1.0 - initial release
// ============================================================================
package mux_scan_sequencer_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Default scan geometry
  localparam int DEF_N_CH  = 4;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_DWELL = 2;

  // Dwell counter width: at least one bit, even when DWELL is 1
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_sequencer_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer_dwell_timer
// Purpose  : Counts settle cycles while enabled; done is high during the
//            last dwell cycle so the owner can sample on that edge. The
//            counter wraps to zero on its own after each completed dwell.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer_dwell_timer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int            CW   = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and wrap at the last cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en & ~clr & (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer
// Purpose  : Round-robin scanner around a 4:1 mux. Steps sel through every
//            channel, samples mux_out after a dwell, packs one bit per
//            channel into a word and offers it on a valid/ready handshake.
// Option   : MUX_SCAN_CONTINUOUS_EN - when defined, a handshake restarts
//            the scan immediately instead of returning to idle.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = DEF_DWELL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_CH-1:0]  word,
  output logic             word_valid,
  input  logic             word_ready
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  word_q, word_d;
  logic             word_valid_q, word_valid_d;

  logic dwell_clr;
  logic dwell_en;
  logic dwell_done;

  // The timer only runs while scanning; any other state holds it at zero
  assign dwell_en  = (state_q == ST_SCAN);
  assign dwell_clr = (state_q != ST_SCAN);

  mux_scan_sequencer_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (dwell_clr),
    .en   (dwell_en),
    .done (dwell_done)
  );

  // Scan FSM: select stepping, per-channel capture and word hand-off
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    shadow_d     = shadow_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          sel_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_SCAN: begin
        if (dwell_done) begin
          for (int k = 0; k < N_CH; k++) begin
            if (sel_q == SEL_W'(k)) begin
              shadow_d[k] = mux_out;
            end
          end
          if (sel_q != LAST_SEL) begin
            sel_d = sel_q + 1'b1;
          end else begin
            // Publish the word including the bit captured on this edge
            word_d       = shadow_d;
            word_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          sel_d        = '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
          state_d      = ST_SCAN;
`else
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any scan in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      shadow_q     <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      shadow_q     <= shadow_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_sequencer
// Purpose  : Self-checking bench for mux_scan_sequencer. A behavioural 4:1
//            mux (mux_out = x[sel]) closes the loop; expected words are
//            queued when a scan starts and compared when word_valid shows.
//            Build with MUX_SCAN_CONTINUOUS_EN to exercise continuous mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

  localparam int NCH = 4;
  localparam int DW  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // DUT with default dwell
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] x     = 4'b0000;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] word;
  logic       word_valid;

  // DUT with single-cycle dwell
  logic       start1 = 1'b0;
  logic       ready1 = 1'b0;
  logic [3:0] x1     = 4'b0000;
  logic       mux_out1;
  logic [1:0] sel1;
  logic       busy1;
  logic [3:0] word1;
  logic       word_valid1;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Behavioural 4:1 mux in front of each scanner
  assign mux_out  = x[sel];
  assign mux_out1 = x1[sel1];

  mux_scan_sequencer #(.N_CH(4), .SEL_W(2), .DWELL(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mux_out    (mux_out),
    .sel        (sel),
    .busy       (busy),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (ready)
  );

  mux_scan_sequencer #(.N_CH(4), .SEL_W(2), .DWELL(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .mux_out    (mux_out1),
    .sel        (sel1),
    .busy       (busy1),
    .word       (word1),
    .word_valid (word_valid1),
    .word_ready (ready1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (word !== 4'b0000) begin bad++; $display("FAIL reset_word got=%b exp=0000", word); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    total++; if (sel1 !== 2'd0 || word_valid1 !== 1'b0) begin bad++; $display("FAIL reset_dut1 sel=%0d valid=%b exp=0/0", sel1, word_valid1); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Full scan with x=1010: sel stepping, valid timing, word content
  task automatic test_scan();
    logic [3:0] e;
    x = 4'b1010;
    start = 1'b1;
    exp_q.push_back(x);
    tick();
    start = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      total++; if (sel !== ((j < 8) ? 2'(j / 2) : 2'd3)) begin bad++; $display("FAIL scan_sel E0+%0d got=%0d exp=%0d", j, sel, (j < 8) ? j / 2 : 3); end
      total++; if (word_valid !== (j == 8)) begin bad++; $display("FAIL scan_valid E0+%0d got=%b exp=%b", j, word_valid, (j == 8)); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy E0+%0d got=%b exp=1", j, busy); end
      if (j < 8) tick();
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    total++; if (word !== e) begin bad++; $display("FAIL scan_word got=%b exp=%b", word, e); end
  endtask

  // Back-pressure in HOLD, then handshake
  task automatic test_hold();
    ready = 1'b0;
    x = 4'b0101;
    for (int j = 0; j < 5; j++) begin
      tick();
      total++; if (word !== 4'b1010 || sel !== 2'd3 || word_valid !== 1'b1 || busy !== 1'b1) begin
        bad++; $display("FAIL hold_stable c=%0d got word=%b sel=%0d valid=%b busy=%b exp 1010/3/1/1", j, word, sel, word_valid, busy);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL hs_valid got=%b exp=0", word_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hs_busy got=%b exp=0", busy); end
    total++; if (word !== 4'b1010) begin bad++; $display("FAIL hs_word got=%b exp=1010", word); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL hs_sel got=%0d exp=0", sel); end
  endtask

  // start re-pulsed mid-scan and during the handshake is ignored
  task automatic test_start_ignored();
    logic [3:0] e;
    x = 4'b1010;
    start = 1'b1;
    exp_q.push_back(x);
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL ign_valid got=%b exp=1", word_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    total++; if (word !== e) begin bad++; $display("FAIL ign_word got=%b exp=%b", word, e); end
    ready = 1'b1;
    start = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      total++; if (word_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL ign_idle c=%0d got valid=%b busy=%b exp 0/0", j, word_valid, busy);
      end
      tick();
    end
  endtask

  // Asynchronous reset mid-scan, then a fresh complete scan
  task automatic test_reset_midscan();
    logic [3:0] e;
    x = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    rst = 1'b1;
    #1;
    total++; if (sel !== 2'd0 || busy !== 1'b0 || word_valid !== 1'b0 || word !== 4'b0000) begin
      bad++; $display("FAIL rst_mid got sel=%0d busy=%b valid=%b word=%b exp 0/0/0/0000", sel, busy, word_valid, word);
    end
    #1;
    rst = 1'b0;
    x = 4'b0110;
    start = 1'b1;
    exp_q.push_back(x);
    tick();
    start = 1'b0;
    for (int j = 0; j < 7; j++) tick();
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_early_valid got=%b exp=0", word_valid); end
    tick();
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL rst_fresh_valid got=%b exp=1", word_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    total++; if (word !== e) begin bad++; $display("FAIL rst_fresh_word got=%b exp=%b", word, e); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Single-cycle dwell instance: one cycle per channel
  task automatic test_dwell1();
    logic [3:0] e;
    x1 = 4'b0111;
    start1 = 1'b1;
    exp_q.push_back(x1);
    tick();
    start1 = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      total++; if (sel1 !== ((j < 4) ? 2'(j) : 2'd3)) begin bad++; $display("FAIL d1_sel E0+%0d got=%0d exp=%0d", j, sel1, (j < 4) ? j : 3); end
      total++; if (word_valid1 !== (j == 4)) begin bad++; $display("FAIL d1_valid E0+%0d got=%b exp=%b", j, word_valid1, (j == 4)); end
      if (j < 4) tick();
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
    total++; if (word1 !== e) begin bad++; $display("FAIL d1_word got=%b exp=%b", word1, e); end
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    total++; if (word_valid1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL d1_hs got valid=%b busy=%b exp 0/0", word_valid1, busy1); end
  endtask

`ifdef MUX_SCAN_CONTINUOUS_EN
  // Continuous scanning with ready tied high and x changing every cycle
  task automatic test_continuous();
    logic [3:0] expw;
    logic [3:0] e;
    int off;
    int nxt;
    int words;
    expw  = 4'b0000;
    words = 0;
    ready = 1'b1;
    x     = 4'(($urandom_range(0, 15)));
    start = 1'b1;
    tick();
    start = 1'b0;
    off = 0;
    for (int c = 0; c < 4 * (NCH * DW + 1); c++) begin
      nxt = (off == NCH * DW) ? 0 : off + 1;
      if (nxt != 0 && (nxt % DW) == 0) expw[nxt / DW - 1] = x;
      tick();
      off = nxt;
      x = 4'(($urandom_range(0, 15)));
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy c=%0d got=%b exp=1", c, busy); end
      total++; if (word_valid !== (off == NCH * DW)) begin bad++; $display("FAIL cont_valid c=%0d got=%b exp=%b", c, word_valid, (off == NCH * DW)); end
      if (off == NCH * DW) begin
        exp_q.push_back(expw);
        e = exp_q.pop_front();
        words++;
        total++; if (word !== e) begin bad++; $display("FAIL cont_word n=%0d got=%b exp=%b", words, word, e); end
      end
    end
    total++; if (words < 3) begin bad++; $display("FAIL cont_count got=%0d exp>=3", words); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MUX_SCAN_CONTINUOUS_EN
    test_continuous();
`else
    test_scan();
    test_hold();
    test_start_ignored();
    test_reset_midscan();
    test_dwell1();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
